// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and load/store (LS) with a fetch starvation guard.
// Optional macro MEM_ARB_PERF_EN adds saturating performance counters.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_ls,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_ls_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_LS, DONE_IF, DONE_LS} state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t     state;
  logic [7:0] starve_cnt;
  logic       ls_win;

  assign ls_win   = ls_req && (!if_req || (starve_cnt < MAX_WAIT_C));
  assign stall_if = if_req & ~if_ack;
  assign stall_ls = ls_req & ~ls_ack;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_ack     <= 1'b0;
      ls_ack     <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      case (state)
        IDLE: begin
          // LS grants only count against fetch while fetch is actually waiting
          if (!if_req)
            starve_cnt <= '0;
          else if (ls_win)
            starve_cnt <= starve_cnt + 8'd1;
          else
            starve_cnt <= '0;
          if (ls_win) begin
            mem_req   <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            state     <= BUSY_LS;
          end else if (if_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= BUSY_IF;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_ack   <= 1'b1;
            state    <= DONE_IF;
          end
        end
        BUSY_LS: begin
          if (mem_ready) begin
            if (!mem_we)
              ls_rdata <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            ls_ack  <= 1'b1;
            state   <= DONE_LS;
          end
        end
        DONE_IF, DONE_LS: state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_cnt       <= '0;
      perf_ls_cnt       <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (state == DONE_IF && perf_if_cnt != '1)
        perf_if_cnt <= perf_if_cnt + 32'd1;
      if (state == DONE_LS && perf_ls_cnt != '1)
        perf_ls_cnt <= perf_ls_cnt + 32'd1;
      if (state == IDLE && if_req && ls_req && perf_conflict_cnt != '1)
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
  logic        if_ack, ls_ack, mem_req, mem_we, stall_if, stall_ls, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_cnt, perf_ls_cnt, perf_conflict_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_ls(stall_ls), .busy(busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_if_cnt(perf_if_cnt), .perf_ls_cnt(perf_ls_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- requester / memory agents ----------------
  typedef struct { logic we; logic [31:0] a; logic [31:0] d; } ls_t;
  logic [31:0] if_q[$];
  ls_t         ls_q[$];
  int          if_rp = 0, ls_rp = 0;
  int          flush_gen = 0, flush_seen = 0;
  int          lat = 0, wc = 0;
  bit          stray = 0, rand_mode = 0;
  bit          if_ack_d = 0, ls_ack_d = 0;
  byte         ack_log[$];

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      if_req = 1'($urandom); ls_req = 1'($urandom); ls_we = 1'($urandom);
      if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom;
      mem_ready = 1'($urandom); mem_rdata = $urandom;
    end else begin
      if (flush_gen != flush_seen) begin
        flush_seen = flush_gen;
        if_rp = if_q.size();
        ls_rp = ls_q.size();
      end else begin
        if (if_ack_d) if_rp++;
        if (ls_ack_d) ls_rp++;
      end
      if (if_rp < if_q.size()) begin if_req = 1'b1; if_addr = if_q[if_rp]; end
      else if_req = 1'b0;
      if (ls_rp < ls_q.size()) begin
        ls_req = 1'b1; ls_we = ls_q[ls_rp].we; ls_addr = ls_q[ls_rp].a; ls_wdata = ls_q[ls_rp].d;
      end else ls_req = 1'b0;
      if (!mem_req) wc = 0;
      mem_ready = (mem_req && wc >= lat) || stray;
      if (mem_req && !mem_ready) wc++;
      mem_rdata = mem_ready ? mem_f(mem_addr) : 32'h0BADF00D;
    end
  end

  initial forever begin
    @(negedge clk);
    if_ack_d = if_ack;
    ls_ack_d = ls_ack;
    if (ls_ack) ack_log.push_back("L");
    if (if_ack) ack_log.push_back("I");
  end

  // ---------------- transaction-level reference model ----------------
  int          m_phase = 0;   // 0 free, 1 memory outstanding, 2 completion cycle
  bit          m_ls = 0, m_we = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_ls_rd = '0;
  int          m_starve = 0, m_pif = 0, m_pls = 0, m_pconf = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_ls <= 0; m_we <= 0; m_addr <= '0; m_wdata <= '0;
      m_if_rd <= '0; m_ls_rd <= '0; m_starve <= 0; m_pif <= 0; m_pls <= 0; m_pconf <= 0;
    end else begin
      case (m_phase)
        0: begin
          if (if_req && ls_req) m_pconf <= m_pconf + 1;
          if (ls_req && (!if_req || m_starve < MAXW)) begin
            m_ls <= 1; m_we <= ls_we; m_addr <= ls_addr; m_wdata <= ls_wdata; m_phase <= 1;
            m_starve <= if_req ? ((m_starve + 1 > MAXW) ? MAXW : m_starve + 1) : 0;
          end else if (if_req) begin
            m_ls <= 0; m_we <= 0; m_addr <= if_addr; m_wdata <= '0; m_phase <= 1; m_starve <= 0;
          end else m_starve <= 0;
        end
        1: if (mem_ready) begin
          if (!m_ls) m_if_rd <= mem_rdata;
          else if (!m_we) m_ls_rd <= mem_rdata;
          m_phase <= 2;
        end
        default: begin
          if (m_ls) m_pls <= m_pls + 1; else m_pif <= m_pif + 1;
          m_phase <= 0;
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    chk("mem_req",   mem_req,   m_phase == 1);
    chk("mem_we",    mem_we,    m_phase == 1 && m_we);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_ack",    if_ack,    m_phase == 2 && !m_ls);
    chk("ls_ack",    ls_ack,    m_phase == 2 && m_ls);
    chk("if_rdata",  if_rdata,  m_if_rd);
    chk("ls_rdata",  ls_rdata,  m_ls_rd);
    chk("busy",      busy,      m_phase != 0);
    chk("stall_if",  stall_if,  if_req && !(m_phase == 2 && !m_ls));
    chk("stall_ls",  stall_ls,  ls_req && !(m_phase == 2 && m_ls));
`ifdef MEM_ARB_PERF_EN
    chk("perf_if",   perf_if_cnt,       m_pif);
    chk("perf_ls",   perf_ls_cnt,       m_pls);
    chk("perf_conf", perf_conflict_cnt, m_pconf);
`endif
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (if_rp == if_q.size() && ls_rp == ls_q.size() && !busy) break;
    end
    if (k == 400) chk("wait_idle_timeout", 1, 0);
  endtask

  function automatic ls_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
    ls_t t;
    t.we = we; t.a = a; t.d = d;
    return t;
  endfunction

  initial begin
    int s, nreq, nack;
    logic [95:0] pat, exp_pat;
    logic [15:0] tie, exp_tie;

    // reset with random inputs
    rand_mode = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rdata", {if_rdata, ls_rdata}, 0);
    rand_mode = 0;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // single fetch, zero extra wait
    lat = 0;
    if_q.push_back(32'h10);
    @(negedge clk);
    chk("f_c0_stall", stall_if, 1);
    chk("f_c0_busy", busy, 0);
    @(negedge clk);
    chk("f_c1_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h10});
    chk("f_c1_stall", stall_if, 1);
    @(negedge clk);
    chk("f_c2_ack", {if_ack, if_rdata}, {1'b1, 32'hDEADBEEF});
    chk("f_c2_stall", stall_if, 0);
    wait_idle();

    // stray mem_ready while idle must be ignored
    stray = 1;
    repeat (3) @(negedge clk);
    chk("stray_idle", {busy, if_ack, ls_ack}, 0);
    stray = 0;

    // tie: both rise together, LS first
    s = ack_log.size();
    if_q.push_back(32'h40);
    ls_q.push_back(mk(1'b0, 32'h80, 32'h0));
    wait_idle();
    exp_tie = "LI";
    tie = (ack_log.size() >= s + 2) ? {ack_log[s], ack_log[s+1]} : 16'h0;
    chk("tie_order", tie, exp_tie);
    chk("tie_ls_rdata", ls_rdata, 32'h0080FF7F);
    chk("tie_if_rdata", if_rdata, 32'h0040FFBF);

    // delayed store, ready 3 cycles after request
    lat = 3; nreq = 0; nack = 0;
    ls_q.push_back(mk(1'b1, 32'h20, 32'h12345678));
    repeat (12) begin
      @(negedge clk);
      if (mem_req) begin
        nreq++;
        chk("st_fields", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h20, 32'h12345678});
      end
      if (ls_ack) nack++;
    end
    chk("st_req_cycles", nreq, 4);
    chk("st_ack_pulses", nack, 1);
    chk("st_ls_rdata_kept", ls_rdata, 32'h0080FF7F);
    wait_idle();

    // starvation guard: fetch waits at most MAX_WAIT LS grants
    lat = 0;
    s = ack_log.size();
    if_q.push_back(32'h100);
    if_q.push_back(32'h104);
    for (int i = 0; i < 10; i++) ls_q.push_back(mk(1'b0, 32'h200 + 32'(4 * i), 32'h0));
    wait_idle();
    exp_pat = "LLLLILLLLILL";
    pat = '0;
    if (ack_log.size() >= s + 12)
      for (int i = 0; i < 12; i++) pat[8*(11-i) +: 8] = ack_log[s+i];
    chk("starve_order", pat, exp_pat);

    // reset while memory is outstanding
    lat = 1000;
    ls_q.push_back(mk(1'b0, 32'h30, 32'h0));
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        @(negedge clk);
        if (mem_req) break;
      end
      if (k == 20) chk("midrst_req_timeout", 1, 0);
    end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_ack", {if_ack, ls_ack}, 0);
`ifdef MEM_ARB_PERF_EN
    chk("midrst_perf", {perf_if_cnt, perf_ls_cnt, perf_conflict_cnt}, 0);
`endif
    flush_gen++;
    lat = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    nack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ls_ack) nack++;
    end
    chk("midrst_no_ack", nack, 0);

    // post-reset sanity: a load still completes
    ls_q.push_back(mk(1'b0, 32'h44, 32'h0));
    wait_idle();
    chk("post_rst_load", ls_rdata, 32'h0044FFBB);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
